// File: rtl/seq_bus_player_if.sv
// Register-write bus shared by the host port, the step sequencer and the signal generator.
// The player owns the master side; host requests come in and generator writes go out.
interface seq_bus_player_if;
   logic       host_we;
   logic [2:0] host_addr;
   logic [4:0] host_data;
   logic       host_ready;
   logic       write_strobe;
   logic [2:0] address;
   logic [4:0] data;

   modport master (
      input  host_we, host_addr, host_data,
      output host_ready, write_strobe, address, data
   );

   modport slave (
      output host_we, host_addr, host_data,
      input  host_ready, write_strobe, address, data
   );
endinterface

// File: rtl/seq_bus_player.sv
// Step sequencer that replays a pattern as register-write bursts (noteA, noteB, enables)
// and arbitrates host writes onto the same generator bus, sequencer first.
module seq_bus_player #(
   parameter int STEPS = 16,
   parameter int SW    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stop,
   input  logic [15:0]     tempo,
   input  logic            cfg_we,
   input  logic [SW-1:0]   cfg_addr,
   input  logic [13:0]     cfg_data,
   seq_bus_player_if.master bus,
   output logic            playing,
   output logic [SW-1:0]   step_o
);

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_EN, WAIT, MUTE} state_t;

   state_t        state;
   state_t        next_state;
   logic [13:0]   pattern [STEPS];
   logic [13:0]   step_word;
   logic [SW-1:0] idx;
   logic [SW-1:0] entry_idx;
   logic [SW-1:0] adv_idx;
   logic [15:0]   period;
   logic [15:0]   count;
   logic          stop_pending;
   logic          stop_any;
   logic          mute_done;
   logic          seq_now;
   logic          seq_next;

   // Each bus-owning state produces its strobe in the following cycle, so the host is
   // locked out both while in such a state and on the cycle that transitions into one.
   always_comb begin
      next_state = state;
      stop_any   = stop | stop_pending;
      entry_idx  = (state == IDLE) ? '0 : idx;
      adv_idx    = (step_word[13] || idx == SW'(STEPS - 1)) ? '0 : idx + SW'(1);
      case (state)
         IDLE:    if (start && !stop) next_state = WR_A;
         WR_A:    next_state = WR_B;
         WR_B:    next_state = WR_EN;
         WR_EN:   next_state = stop_any ? MUTE : WAIT;
         WAIT: begin
            if (stop_any)
               next_state = MUTE;
            else if (count == period - 16'd1)
               next_state = WR_A;
         end
         MUTE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      seq_now        = state inside {WR_A, WR_B, WR_EN, MUTE};
      seq_next       = next_state inside {WR_A, WR_B, WR_EN, MUTE};
      bus.host_ready = !(seq_now || seq_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         count            <= '0;
         period           <= 16'd4;
         step_word        <= '0;
         idx              <= '0;
         step_o           <= '0;
         stop_pending     <= 1'b0;
         mute_done        <= 1'b0;
         playing          <= 1'b0;
         bus.write_strobe <= 1'b0;
         bus.address      <= '0;
         bus.data         <= '0;
         for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
      end else begin
         state <= next_state;
         count <= (next_state == WR_A) ? '0 : count + 16'd1;
         if (cfg_we) pattern[cfg_addr] <= cfg_data;

         // The step word and tempo are frozen at burst start; a same-edge cfg write lands later.
         if (next_state == WR_A) begin
            idx       <= entry_idx;
            step_word <= pattern[entry_idx];
            step_o    <= entry_idx;
            period    <= (tempo < 16'd4) ? 16'd4 : tempo;
         end
         if (state == WR_EN) idx <= adv_idx;

         if (next_state == MUTE || state == IDLE)
            stop_pending <= 1'b0;
         else if (stop)
            stop_pending <= 1'b1;

         mute_done <= (state == MUTE);
         if (mute_done) playing <= 1'b0;
         if (next_state == WR_A) playing <= 1'b1;

         bus.write_strobe <= 1'b0;
         bus.address      <= '0;
         bus.data         <= '0;
         case (state)
            WR_A: begin
               bus.write_strobe <= 1'b1;
               bus.address      <= 3'd0;
               bus.data         <= step_word[4:0];
            end
            WR_B: begin
               bus.write_strobe <= 1'b1;
               bus.address      <= 3'd1;
               bus.data         <= step_word[9:5];
            end
            WR_EN: begin
               bus.write_strobe <= 1'b1;
               bus.address      <= 3'd5;
               bus.data         <= {2'b00, step_word[12:10]};
            end
            MUTE: begin
               bus.write_strobe <= 1'b1;
               bus.address      <= 3'd5;
               bus.data         <= 5'd0;
            end
            default: begin
               if (bus.host_we && bus.host_ready) begin
                  bus.write_strobe <= 1'b1;
                  bus.address      <= bus.host_addr;
                  bus.data         <= bus.host_data;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bus_player.sv
// Randomized bench for seq_bus_player: a step-list model predicts every bus cycle,
// and each scenario task compares the per-cycle log against it.
module tb_seq_bus_player;
   localparam int STEPS = 16;
   localparam int SW    = 4;
   localparam int LOGN  = 4096;
   localparam logic [8:0] HOST_WR = {1'b1, 3'd2, 5'd5};

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [15:0]   tempo;
   logic          cfg_we;
   logic [SW-1:0] cfg_addr;
   logic [13:0]   cfg_data;
   logic          playing;
   logic [SW-1:0] step_o;

   seq_bus_player_if bus();

   seq_bus_player #(.STEPS(STEPS), .SW(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .tempo(tempo),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .bus(bus), .playing(playing), .step_o(step_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   logic [8:0]    log_bus  [LOGN];
   logic          log_rdy  [LOGN];
   logic          log_play [LOGN];
   logic [SW-1:0] log_step [LOGN];
   logic [8:0]    exp_bus  [LOGN];
   int            exp_step [LOGN];

   logic [13:0] pat [STEPS];
   int          upd_edge = -1;
   int          upd_addr = 0;
   logic [13:0] upd_word = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOGN) begin
         log_bus[cyc]  = {bus.write_strobe, bus.address, bus.data};
         log_rdy[cyc]  = bus.host_ready;
         log_play[cyc] = playing;
         log_step[cyc] = step_o;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Playback as the musician sees it: burst j starts P*j cycles after start and plays
   // the step chosen by the last/wrap rule; a cfg write only affects later latches.
   task automatic model_playback(input int t, input int tp, input int nb);
      int p;
      int e;
      int idx;
      logic [13:0] w;
      p   = (tp < 4) ? 4 : tp;
      idx = 0;
      for (int c = t; c <= t + nb * p + 3 && c < LOGN; c++) begin
         exp_bus[c]  = '0;
         exp_step[c] = -1;
      end
      for (int j = 0; j < nb; j++) begin
         e = t + j * p;
         if (upd_edge >= 0 && e > upd_edge) pat[upd_addr] = upd_word;
         w = pat[idx];
         exp_bus[e + 1] = {1'b1, 3'd0, w[4:0]};
         exp_bus[e + 2] = {1'b1, 3'd1, w[9:5]};
         exp_bus[e + 3] = {1'b1, 3'd5, 2'b00, w[12:10]};
         exp_step[e]    = idx;
         idx = (w[13] || idx == STEPS - 1) ? 0 : idx + 1;
      end
   endtask

   task automatic program_word(input int a, input logic [13:0] w);
      cfg_we   = 1'b1;
      cfg_addr = a[SW-1:0];
      cfg_data = w;
      @(posedge clk); #2;
      cfg_we   = 1'b0;
   endtask

   task automatic program_all();
      for (int i = 0; i < STEPS; i++) program_word(i, pat[i]);
   endtask

   task automatic pulse_start(output int t);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      t = cyc;
   endtask

   task automatic stop_playback(output int waited);
      stop = 1'b1;
      @(posedge clk); #2;
      stop = 1'b0;
      waited = -1;
      for (int i = 0; i < 100; i++) begin
         if (!playing) begin
            waited = i;
            break;
         end
         @(posedge clk); #2;
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (bus.write_strobe !== 1'b0) $display("[TB] FAIL reset_strobe: got %b expected 0", bus.write_strobe); else passed++;
      checks++; if (bus.address !== 3'd0) $display("[TB] FAIL reset_address: got %0d expected 0", bus.address); else passed++;
      checks++; if (bus.data !== 5'd0) $display("[TB] FAIL reset_data: got %0d expected 0", bus.data); else passed++;
      checks++; if (playing !== 1'b0) $display("[TB] FAIL reset_playing: got %b expected 0", playing); else passed++;
      checks++; if (step_o !== '0) $display("[TB] FAIL reset_step: got %0d expected 0", step_o); else passed++;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (bus.host_ready !== 1'b1) $display("[TB] FAIL idle_host_ready: got %b expected 1", bus.host_ready); else passed++;
      checks++; if ({bus.write_strobe, bus.address, bus.data} !== 9'd0) $display("[TB] FAIL idle_bus: got %h expected 000", {bus.write_strobe, bus.address, bus.data}); else passed++;
   endtask

   task automatic test_directed_pattern();
      int t;
      int waited;
      pat[0] = {1'b0, 3'b111, 5'd9, 5'd3};
      pat[1] = {1'b1, 3'b010, 5'd4, 5'd7};
      program_word(0, pat[0]);
      program_word(1, pat[1]);
      tempo = 16'd10;
      pulse_start(t);
      repeat (22) @(posedge clk);
      #2;
      model_playback(t, 10, 3);
      for (int c = t; c <= t + 21; c++) begin
         checks++;
         if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL directed_bus cyc+%0d: got %h expected %h", c - t, log_bus[c], exp_bus[c]); else passed++;
         if (exp_step[c] >= 0) begin
            checks++;
            if (log_step[c] !== SW'(exp_step[c])) $display("[TB] FAIL directed_step cyc+%0d: got %0d expected %0d", c - t, log_step[c], exp_step[c]); else passed++;
         end
      end
      checks++; if (log_bus[t + 1] !== {1'b1, 3'd0, 5'd3}) $display("[TB] FAIL directed_first_note: got %h expected 103", log_bus[t + 1]); else passed++;
      checks++; if (log_bus[t + 13] !== {1'b1, 3'd5, 5'd2}) $display("[TB] FAIL directed_step1_enables: got %h expected 1a2", log_bus[t + 13]); else passed++;
      checks++; if (log_bus[t + 21] !== {1'b1, 3'd0, 5'd3}) $display("[TB] FAIL directed_loop: got %h expected 103", log_bus[t + 21]); else passed++;
      checks++; if (log_play[t] !== 1'b1) $display("[TB] FAIL directed_playing: got %b expected 1", log_play[t]); else passed++;
      checks++; if (log_rdy[t] !== 1'b0) $display("[TB] FAIL directed_ready_before_burst: got %b expected 0", log_rdy[t]); else passed++;
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL directed_stop: got timeout expected idle"); else passed++;
   endtask

   task automatic test_min_tempo();
      int t;
      int waited;
      int q[$];
      tempo = 16'd2;
      pulse_start(t);
      repeat (20) @(posedge clk);
      #2;
      model_playback(t, 2, 5);
      for (int c = t; c < t + 20; c++) begin
         checks++;
         if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL min_tempo_bus cyc+%0d: got %h expected %h", c - t, log_bus[c], exp_bus[c]); else passed++;
         if (log_bus[c][8] && log_bus[c][7:5] == 3'd0) q.push_back(c);
      end
      checks++; if (q.size() != 5) $display("[TB] FAIL min_tempo_count: got %0d expected 5", q.size()); else passed++;
      for (int i = 1; i < q.size(); i++) begin
         checks++;
         if (q[i] - q[i - 1] != 4) $display("[TB] FAIL min_tempo_spacing: got %0d expected 4", q[i] - q[i - 1]); else passed++;
      end
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL min_tempo_stop: got timeout expected idle"); else passed++;
   endtask

   task automatic test_random_playback();
      int t;
      int tp;
      int nb;
      int p;
      int waited;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < STEPS; i++) begin
            pat[i] = 14'($urandom);
            pat[i][13] = ($urandom_range(0, 5) == 0);
         end
         program_all();
         tp = $urandom_range(0, 12);
         nb = $urandom_range(3, 6);
         p  = (tp < 4) ? 4 : tp;
         tempo = 16'(tp);
         pulse_start(t);
         repeat (nb * p) @(posedge clk);
         #2;
         model_playback(t, tp, nb);
         for (int c = t; c < t + nb * p; c++) begin
            checks++;
            if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL random_bus tempo=%0d cyc+%0d: got %h expected %h", tp, c - t, log_bus[c], exp_bus[c]); else passed++;
            if (exp_step[c] >= 0) begin
               checks++;
               if (log_step[c] !== SW'(exp_step[c])) $display("[TB] FAIL random_step cyc+%0d: got %0d expected %0d", c - t, log_step[c], exp_step[c]); else passed++;
            end
         end
         stop_playback(waited);
         checks++; if (waited < 0) $display("[TB] FAIL random_stop: got timeout expected idle"); else passed++;
      end
   endtask

   task automatic test_host_arbitration();
      int t;
      int o;
      int waited;
      bus.host_we   = 1'b1;
      bus.host_addr = 3'd2;
      bus.host_data = 5'd5;
      tempo = 16'd10;
      @(posedge clk); #2;
      pulse_start(t);
      repeat (40) @(posedge clk);
      #2;
      bus.host_we = 1'b0;
      model_playback(t, 10, 4);
      for (int c = t + 1; c < t + 40; c++) begin
         o = (c - t) % 10;
         checks++;
         if (o >= 1 && o <= 3) begin
            if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL host_seq_slot cyc+%0d: got %h expected %h", c - t, log_bus[c], exp_bus[c]); else passed++;
            checks++;
            if (log_rdy[c - 1] !== 1'b0) $display("[TB] FAIL host_ready_before_burst cyc+%0d: got %b expected 0", c - t - 1, log_rdy[c - 1]); else passed++;
         end else if (o >= 4) begin
            if (log_bus[c] !== HOST_WR) $display("[TB] FAIL host_gap_write cyc+%0d: got %h expected %h", c - t, log_bus[c], HOST_WR); else passed++;
         end else begin
            if (log_bus[c] !== 9'd0 && log_bus[c] !== HOST_WR) $display("[TB] FAIL host_edge_slot cyc+%0d: got %h expected 000 or %h", c - t, log_bus[c], HOST_WR); else passed++;
         end
      end
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL host_stop: got timeout expected idle"); else passed++;
   endtask

   task automatic test_stop_during_burst();
      int t;
      int t2;
      int waited;
      tempo = 16'd8;
      pulse_start(t);
      @(posedge clk); #2;
      stop = 1'b1;
      @(posedge clk); #2;
      stop = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      model_playback(t, 8, 1);
      for (int c = t + 1; c <= t + 3; c++) begin
         checks++;
         if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL stop_burst_completes cyc+%0d: got %h expected %h", c - t, log_bus[c], exp_bus[c]); else passed++;
      end
      checks++; if (log_bus[t + 4] !== {1'b1, 3'd5, 5'd0}) $display("[TB] FAIL stop_mute_write: got %h expected 1a0", log_bus[t + 4]); else passed++;
      for (int c = t + 5; c <= t + 7; c++) begin
         checks++;
         if (log_bus[c] !== 9'd0) $display("[TB] FAIL stop_quiet cyc+%0d: got %h expected 000", c - t, log_bus[c]); else passed++;
      end
      checks++; if (log_play[t + 4] !== 1'b1) $display("[TB] FAIL stop_playing_during_mute: got %b expected 1", log_play[t + 4]); else passed++;
      checks++; if (log_play[t + 5] !== 1'b0) $display("[TB] FAIL stop_playing_after_mute: got %b expected 0", log_play[t + 5]); else passed++;
      pulse_start(t2);
      repeat (4) @(posedge clk);
      #2;
      checks++; if (log_step[t2] !== '0) $display("[TB] FAIL restart_step: got %0d expected 0", log_step[t2]); else passed++;
      checks++; if (log_bus[t2 + 1] !== {1'b1, 3'd0, pat[0][4:0]}) $display("[TB] FAIL restart_note: got %h expected %h", log_bus[t2 + 1], {1'b1, 3'd0, pat[0][4:0]}); else passed++;
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL restart_stop: got timeout expected idle"); else passed++;
   endtask

   task automatic test_wrap_and_cfg_race();
      int t;
      int waited;
      logic [13:0] old_word;
      logic [13:0] new_word;
      for (int i = 0; i < STEPS; i++) begin
         pat[i] = 14'($urandom);
         pat[i][13] = 1'b0;
      end
      program_all();
      old_word = pat[0];
      new_word = {1'b0, ~old_word[12:0]};
      tempo = 16'd4;
      pulse_start(t);
      repeat (63) @(posedge clk);
      #2;
      program_word(0, new_word);
      repeat (68) @(posedge clk);
      #2;
      upd_edge = t + 64;
      upd_addr = 0;
      upd_word = new_word;
      model_playback(t, 4, 33);
      upd_edge = -1;
      for (int c = t; c < t + 132; c++) begin
         checks++;
         if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL wrap_bus cyc+%0d: got %h expected %h", c - t, log_bus[c], exp_bus[c]); else passed++;
      end
      checks++; if (log_step[t + 60] !== 4'd15) $display("[TB] FAIL wrap_last_index: got %0d expected 15", log_step[t + 60]); else passed++;
      checks++; if (log_step[t + 64] !== 4'd0) $display("[TB] FAIL wrap_to_zero: got %0d expected 0", log_step[t + 64]); else passed++;
      checks++; if (log_bus[t + 65] !== {1'b1, 3'd0, old_word[4:0]}) $display("[TB] FAIL race_old_word: got %h expected %h", log_bus[t + 65], {1'b1, 3'd0, old_word[4:0]}); else passed++;
      checks++; if (log_bus[t + 129] !== {1'b1, 3'd0, new_word[4:0]}) $display("[TB] FAIL race_new_word: got %h expected %h", log_bus[t + 129], {1'b1, 3'd0, new_word[4:0]}); else passed++;
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL wrap_stop: got timeout expected idle"); else passed++;
   endtask

   task automatic test_reset_mid_burst();
      int t;
      int t2;
      int waited;
      tempo = 16'd6;
      pulse_start(t);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      checks++; if (bus.write_strobe !== 1'b0) $display("[TB] FAIL midreset_strobe: got %b expected 0", bus.write_strobe); else passed++;
      checks++; if (playing !== 1'b0) $display("[TB] FAIL midreset_playing: got %b expected 0", playing); else passed++;
      checks++; if (step_o !== '0) $display("[TB] FAIL midreset_step: got %0d expected 0", step_o); else passed++;
      repeat (4) @(posedge clk);
      #2;
      for (int c = t + 1; c <= t + 4; c++) begin
         checks++;
         if (log_bus[c] !== 9'd0) $display("[TB] FAIL midreset_quiet cyc+%0d: got %h expected 000", c - t, log_bus[c]); else passed++;
      end
      for (int i = 0; i < STEPS; i++) pat[i] = '0;
      tempo = 16'd4;
      pulse_start(t2);
      repeat (12) @(posedge clk);
      #2;
      model_playback(t2, 4, 3);
      for (int c = t2; c < t2 + 12; c++) begin
         checks++;
         if (log_bus[c] !== exp_bus[c]) $display("[TB] FAIL cleared_pattern cyc+%0d: got %h expected %h", c - t2, log_bus[c], exp_bus[c]); else passed++;
         if (exp_step[c] >= 0) begin
            checks++;
            if (log_step[c] !== SW'(exp_step[c])) $display("[TB] FAIL cleared_step cyc+%0d: got %0d expected %0d", c - t2, log_step[c], exp_step[c]); else passed++;
         end
      end
      stop_playback(waited);
      checks++; if (waited < 0) $display("[TB] FAIL midreset_stop: got timeout expected idle"); else passed++;
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      stop          = 1'b0;
      tempo         = '0;
      cfg_we        = 1'b0;
      cfg_addr      = '0;
      cfg_data      = '0;
      bus.host_we   = 1'b0;
      bus.host_addr = '0;
      bus.host_data = '0;
      for (int i = 0; i < STEPS; i++) pat[i] = '0;
      @(posedge clk); #2;
      test_reset();
      test_directed_pattern();
      test_min_tempo();
      test_random_playback();
      test_host_arbitration();
      test_stop_during_burst();
      test_wrap_and_cfg_race();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
